// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : vertical line counter and registered VGA sync/visible timing
// Revision     : 1.0
// ============================================================================
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic [9:0] HcntValue,
   input  logic       VcntEnable,
   output logic [9:0] VcntValue,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   localparam logic [9:0] c_H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0] c_HS_START  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] c_V_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0] c_VS_START  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] c_V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic w_h_vis;
   logic w_v_vis;
   logic w_visible;
   logic w_hs_win;
   logic w_vs_win;
   logic w_wrap;

   always_comb begin
      w_h_vis   = (HcntValue < c_H_VIS);
      w_v_vis   = (VcntValue < c_V_VIS);
      w_visible = w_h_vis && w_v_vis;
      w_hs_win  = (HcntValue >= c_HS_START) && (HcntValue < c_HS_END);
      w_vs_win  = (VcntValue >= c_VS_START) && (VcntValue < c_VS_END);
      // >= rather than == so an out-of-range count still recovers to line 0
      w_wrap    = VcntEnable && (VcntValue >= c_V_LAST);
   end

   always_ff @(posedge vga_clk or negedge reset) begin
      if (!reset) begin
         VcntValue   <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_start <= 1'b0;
      end else begin
         if (w_wrap) begin
            VcntValue <= '0;
         end else if (VcntEnable) begin
            VcntValue <= VcntValue + 10'd1;
         end
         frame_start <= w_wrap;
         // timing outputs use the pre-update line number
         hsync       <= w_hs_win ? SYNC_POL : ~SYNC_POL;
         vsync       <= w_vs_win ? SYNC_POL : ~SYNC_POL;
         video_on    <= w_visible;
         pixel_x     <= w_visible ? HcntValue : 10'd0;
         pixel_y     <= w_visible ? VcntValue : 10'd0;
      end
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Downstream stage of the horizontal pixel counter. It consumes the horizontal count and the line-advance pulse.
- Maintains the vertical line counter and generates registered VGA timing: hsync, vsync, video_on, pixel coordinates and a frame-start pulse.
- Feeds the pixel/colour generator and the VGA connector pins.
- Default timing is 640x480 @ 60 Hz.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum of the four V_ values = 525
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
vga_clk  input  1  pixel clock, rising edge
reset  input  1  asynchronous, active-low reset
HcntValue  input  10  current horizontal pixel count
VcntEnable  input  1  line-advance pulse, one cycle per line
VcntValue  output  10  current line number, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  high while in the visible region
pixel_x  output  10  visible column, 0 outside the visible region
pixel_y  output  10  visible row, 0 outside the visible region
frame_start  output  1  one-cycle pulse on vertical wrap

Behaviour:
- Reset: asserting reset (low) immediately forces the following, independent of vga_clk:
  - VcntValue=0, pixel_x=0, pixel_y=0
  - video_on=0, frame_start=0
  - hsync=vsync=~SYNC_POL (inactive)
- Reset release: counting resumes on the first rising edge after reset goes high.
- Vertical counter, at each rising edge:
  - VcntEnable=1 and VcntValue>=V_TOTAL-1 -> VcntValue<=0.
  - VcntEnable=1 otherwise -> VcntValue<=VcntValue+1.
  - VcntEnable=0 -> hold.
  - VcntEnable is level-sampled with no edge detection: held high N cycles gives N increments.
- frame_start: registered; equals 1 for exactly the cycle after an edge where VcntEnable=1 and VcntValue>=V_TOTAL-1; 0 otherwise.
- Timing outputs: registered with one-cycle latency. At each edge they are computed from the HcntValue input and the VcntValue register value before that edge (H, V below):
  - hsync = SYNC_POL when H_VISIBLE+H_FRONT <= H < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default); else ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FRONT <= V < V_VISIBLE+V_FRONT+V_SYNC (490..491); else ~SYNC_POL.
  - video_on = (H < H_VISIBLE) && (V < V_VISIBLE).
  - pixel_x = H when the visible condition holds, else 0; pixel_y = V likewise.
- Out-of-range horizontal input: any HcntValue >= H_VISIBLE outside the sync window is blanking (no sync, video_on=0). This includes values beyond the nominal line length.
- Arithmetic: all compares are unsigned 10-bit; parameter sums are constant-folded. The block needs no counter width beyond 10 bits for V_TOTAL <= 1023.
- Simultaneous events:
  - VcntEnable on the wrap line updates VcntValue to 0 and asserts frame_start on the same edge.
  - The timing outputs on that edge still reflect the pre-wrap V.
- Reset mid-frame: all state clears at once. The first post-reset frame starts at line 0 with no frame_start pulse until the next wrap.

Test Plan:
1. Reset low for 3 cycles while HcntValue toggles -> VcntValue=0, hsync=vsync=1, video_on=0, pixel_x=pixel_y=0, frame_start=0 throughout. Outputs change immediately on the reset assertion edge, not at a clock.
2. V=0, sweep HcntValue 0..800, no VcntEnable -> video_on=1 for H 0..639 (one cycle late) with pixel_x=H; hsync=0 exactly for H 656..751; video_on=0 for H 640..800.
3. Pulse VcntEnable once per 801-cycle line for 525 lines:
   - VcntValue steps 0..524 then 0.
   - vsync=0 only while V=490..491.
   - frame_start is high for one cycle exactly at the 524->0 wrap.
4. Hold VcntEnable high 3 consecutive cycles at V=10 -> VcntValue=13; no frame_start.
5. Force V=524, pulse VcntEnable while HcntValue=100 -> VcntValue=0 and frame_start=1 on the next cycle; video_on from that edge =0 (pre-wrap V=524).
6. At V=300, H=200, drop reset -> all outputs at reset values asynchronously. Release reset -> VcntValue stays 0 until the next VcntEnable; video_on=1 one cycle after release with H<640.
